// File: rtl/count_display_pkg.sv
// count_display_pkg: FSM encoding and active-high glyphs for the count display scanner.
package count_display_pkg;
  typedef enum logic [1:0] {
    GAP_TO_ONES = 2'd0,
    SHOW_ONES   = 2'd1,
    GAP_TO_TENS = 2'd2,
    SHOW_TENS   = 2'd3
  } state_e;
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: 4-bit digit to active-high {g,f,e,d,c,b,a} glyph; codes 10-15 are blank.
module bcd_to_7seg
  import count_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = GLYPH_0;
      4'd1:    seg_o = GLYPH_1;
      4'd2:    seg_o = GLYPH_2;
      4'd3:    seg_o = GLYPH_3;
      4'd4:    seg_o = GLYPH_4;
      4'd5:    seg_o = GLYPH_5;
      4'd6:    seg_o = GLYPH_6;
      4'd7:    seg_o = GLYPH_7;
      4'd8:    seg_o = GLYPH_8;
      4'd9:    seg_o = GLYPH_9;
      default: seg_o = GLYPH_BLANK;
    endcase
  end
endmodule

// File: rtl/count_display_scanner.sv
// count_display_scanner: two-digit multiplexed 7-segment driver with per-frame
// snapshot of the upstream count and a blank gap before every digit change.
module count_display_scanner
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  if (REFRESH_DIV < 1) begin : g_bad_div
    $error("REFRESH_DIV must be >= 1");
  end
  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [3:0]      snap_q, snap_d;
  logic            show, last, tens, lit_ones, lit_tens;
  logic [3:0]      ones, digit;
  logic [6:0]      glyph, seg_h;
  always_comb begin
    show    = state_q == SHOW_ONES || state_q == SHOW_TENS;
    last    = show && pre_q == PMAX;
    state_d = (!show || last) ? state_e'(state_q + 2'd1) : state_q;
    pre_d   = (show && !last) ? pre_q + 1'b1 : '0;
    snap_d  = state_q == GAP_TO_ONES ? count : snap_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GAP_TO_ONES;
      pre_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      snap_q  <= snap_d;
    end
  end
  always_comb begin
    tens     = snap_q >= 4'd10;
    ones     = tens ? snap_q - 4'd10 : snap_q;
    digit    = state_q == SHOW_TENS ? {3'b000, tens} : ones;
    lit_ones = state_q == SHOW_ONES;
    lit_tens = state_q == SHOW_TENS && tens;
  end
  bcd_to_7seg u_dec (
    .digit_i(digit),
    .seg_o  (glyph)
  );
  // Leading-zero tens and both gaps share the same all-off decode.
  always_comb begin
    seg_h = (lit_ones || lit_tens) ? glyph : GLYPH_BLANK;
    seg   = SEG_ACTIVE_LOW ? ~seg_h : seg_h;
    an    = SEG_ACTIVE_LOW ? ~{lit_tens, lit_ones} : {lit_tens, lit_ones};
    frame = lit_ones && pre_q == '0;
  end
endmodule

// File: tb/tb_count_display_scanner.sv
// tb_count_display_scanner: random and directed stimulus on REFRESH_DIV=4 and =1
// instances, checked against a frame-position reference model.
module tb_count_display_scanner;
  logic       clk, reset;
  logic [3:0] count;
  logic [6:0] seg4, seg1;
  logic [1:0] an4, an1;
  logic       frame4, frame1;
  int         n_chk, n_pass;
  int         t4, t1, snap4, snap1;
  logic [6:0] glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  count_display_scanner #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .count(count), .seg(seg4), .an(an4), .frame(frame4)
  );
  count_display_scanner #(.REFRESH_DIV(1), .SEG_ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .count(count), .seg(seg1), .an(an1), .frame(frame1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t4=%0d t1=%0d)", tag, got, exp, t4, t1);
  endtask
  // t = edges since reset release; frame slot p: ones [0,r), gap r, tens (r,2r], gap 2r+1.
  function automatic void model(input int r, input int t, input int snap,
                                output logic [6:0] s, output logic [1:0] a, output logic f);
    int p;
    logic [6:0] sh;
    logic [1:0] ah;
    sh = '0;
    ah = '0;
    f  = 1'b0;
    if (t > 0) begin
      p = (t - 1) % (2 * r + 2);
      if (p < r) begin
        ah = 2'b01;
        sh = glyph[snap % 10];
        f  = p == 0;
      end else if (p > r && p <= 2 * r && snap >= 10) begin
        ah = 2'b10;
        sh = glyph[1];
      end
    end
    s = ~sh;
    a = ~ah;
  endfunction
  task automatic compare();
    logic [6:0] s;
    logic [1:0] a;
    logic       f;
    model(4, t4, snap4, s, a, f);
    check("seg4", seg4, s);
    check("an4", an4, a);
    check("frame4", frame4, f);
    model(1, t1, snap1, s, a, f);
    check("seg1", seg1, s);
    check("an1", an1, a);
    check("frame1", frame1, f);
  endtask
  task automatic step();
    @(posedge clk);
    if (reset) begin
      t4 = 0;
      t1 = 0;
    end else begin
      if (t4 % 10 == 0) snap4 = count;
      if (t1 % 4 == 0) snap1 = count;
      t4++;
      t1++;
    end
    @(negedge clk);
    compare();
  endtask
  initial begin
    n_chk = 0; n_pass = 0; t4 = 0; t1 = 0; snap4 = 0; snap1 = 0;
    reset = 1'b1;
    count = 4'd9;
    repeat (3) step();
    reset = 1'b0;
    count = 4'd7;
    repeat (25) step();
    count = 4'd13;
    repeat (24) step();
    count = 4'd5;
    repeat (10) step();
    for (int i = 0; i < 10 && (t4 - 1) % 10 != 6; i++) step();
    count = 4'd12;
    repeat (20) step();
    for (int i = 0; i < 10 && (t4 - 1) % 10 != 1; i++) step();
    reset = 1'b1;
    #1;
    check("async_seg4", seg4, 7'h7F);
    check("async_an4", an4, 2'b11);
    check("async_frame4", frame4, 1'b0);
    check("async_seg1", seg1, 7'h7F);
    check("async_an1", an1, 2'b11);
    step();
    reset = 1'b0;
    count = 4'd7;
    repeat (25) step();
    for (int v = 14; v <= 16; v++) begin
      count = 4'(v % 16);
      repeat (4) step();
    end
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) count = 4'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
